// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory responder: access sizes and FSM states.
package dmem_pkg;

    localparam logic SZ_BYTE = 1'b0;
    localparam logic SZ_WORD = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane helper: extracts and extends a load byte, and merges a store byte into a word.
module dmem_lane_align (
    input  logic [31:0] i_word,
    input  logic [1:0]  i_lane,
    input  logic        i_uns,
    input  logic [7:0]  i_wbyte,
    output logic [31:0] o_load,
    output logic [31:0] o_merged
);

    logic [7:0] w_byte;

    // Lanes are little-endian: lane 0 is bits 7:0.
    always_comb begin
        w_byte   = i_word[7:0];
        o_merged = i_word;
        case (i_lane)
            2'd0: begin w_byte = i_word[7:0];   o_merged[7:0]   = i_wbyte; end
            2'd1: begin w_byte = i_word[15:8];  o_merged[15:8]  = i_wbyte; end
            2'd2: begin w_byte = i_word[23:16]; o_merged[23:16] = i_wbyte; end
            default: begin w_byte = i_word[31:24]; o_merged[31:24] = i_wbyte; end
        endcase
        o_load = i_uns ? {24'b0, w_byte} : {{24{w_byte[7]}}, w_byte};
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, LAT wait states, word array with byte lanes.
// Define DMEM_MISALIGN_EN to flag misaligned word accesses with resp_err instead of forcing alignment.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int LAT    = 2,
    parameter int LAT_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic              req_size,
    input  logic              req_uns,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_err
);

    localparam int               DEPTH   = 2 ** (ADDR_W - 2);
    localparam logic [LAT_W-1:0] LAT_CNT = LAT_W'(LAT);

    logic [31:0]       r_mem [DEPTH];
    state_t            r_state;
    logic [LAT_W-1:0]  r_cnt;
    logic              r_we;
    logic              r_size;
    logic              r_uns;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic              r_req_ready;
    logic              r_resp_valid;
    logic [31:0]       r_rdata;
    logic              r_err;

    logic              w_accept;
    logic              w_exec;
    logic              w_opWe;
    logic              w_opSize;
    logic              w_opUns;
    logic [ADDR_W-1:0] w_opAddr;
    logic [31:0]       w_opWdata;
    logic [31:0]       w_word;
    logic [31:0]       w_byteLoad;
    logic [31:0]       w_merged;
    logic              w_misalign;
    logic [31:0]       w_respData;

    assign req_ready  = r_req_ready;
    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_rdata;
    assign resp_err   = r_err;

    assign w_accept = req_valid & r_req_ready & rst;

    // With no wait states the access executes on the accept edge, straight from the request bus.
    assign w_exec    = (LAT == 0) ? w_accept  : ((r_state == ST_WAIT) && (r_cnt == LAT_W'(1)));
    assign w_opWe    = (LAT == 0) ? req_we    : r_we;
    assign w_opSize  = (LAT == 0) ? req_size  : r_size;
    assign w_opUns   = (LAT == 0) ? req_uns   : r_uns;
    assign w_opAddr  = (LAT == 0) ? req_addr  : r_addr;
    assign w_opWdata = (LAT == 0) ? req_wdata : r_wdata;

    assign w_word = r_mem[w_opAddr[ADDR_W-1:2]];

`ifdef DMEM_MISALIGN_EN
    assign w_misalign = (w_opSize == SZ_WORD) && (w_opAddr[1:0] != 2'b00);
`else
    assign w_misalign = 1'b0;
`endif

    dmem_lane_align u_align (
        .i_word   (w_word),
        .i_lane   (w_opAddr[1:0]),
        .i_uns    (w_opUns),
        .i_wbyte  (w_opWdata[7:0]),
        .o_load   (w_byteLoad),
        .o_merged (w_merged)
    );

    assign w_respData = (w_opWe || w_misalign) ? 32'd0 :
                        (w_opSize == SZ_WORD)  ? w_word : w_byteLoad;

    // The array is deliberately left out of reset; a store only lands on its execute edge.
    always_ff @(posedge clk) begin
        if (w_exec && w_opWe && !w_misalign) begin
            r_mem[w_opAddr[ADDR_W-1:2]] <= (w_opSize == SZ_WORD) ? w_opWdata : w_merged;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_we         <= 1'b0;
            r_size       <= 1'b0;
            r_uns        <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_rdata      <= '0;
            r_err        <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_we        <= req_we;
                        r_size      <= req_size;
                        r_uns       <= req_uns;
                        r_addr      <= req_addr;
                        r_wdata     <= req_wdata;
                        r_cnt       <= LAT_CNT;
                        r_req_ready <= 1'b0;
                        if (LAT == 0) begin
                            r_state      <= ST_RESP;
                            r_resp_valid <= 1'b1;
                            r_rdata      <= w_respData;
                            r_err        <= w_misalign;
                        end else begin
                            r_state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    r_cnt <= r_cnt - LAT_W'(1);
                    if (r_cnt == LAT_W'(1)) begin
                        r_state      <= ST_RESP;
                        r_resp_valid <= 1'b1;
                        r_rdata      <= w_respData;
                        r_err        <= w_misalign;
                    end
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        r_state      <= ST_IDLE;
                        r_resp_valid <= 1'b0;
                        r_req_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_req_ready  <= 1'b1;
                    r_resp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized scoreboard bench for dmem_responder against a byte-array reference model.
module tb_dmem_responder;

    localparam int ADDR_W = 12;
    localparam int LAT    = 2;
    localparam int LAT_W  = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic        req_size = 1'b0;
    logic        req_uns = 1'b0;
    logic [11:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [31:0] resp_rdata;
    logic        resp_err;

    dmem_responder #(.ADDR_W(ADDR_W), .LAT(LAT), .LAT_W(LAT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_uns    (req_uns),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        int          due;
    } exp_t;

    exp_t        expQ[$];
    logic [7:0]  refMem [0:4095];
    int          checks = 0;
    int          passes = 0;
    int          lastAccept = 0;
    bit          randReady = 1'b0;
    bit          inResp = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passes++;
        else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference behaviour from the byte-addressed view of memory.
    function automatic void modelOp(input bit we, input bit size, input bit uns,
                                    input logic [11:0] addr, input logic [31:0] wdata,
                                    output logic [31:0] rdata, output logic err);
        int base;
        bit misal;
        base = int'(addr) & ~3;
`ifdef DMEM_MISALIGN_EN
        misal = size && (addr[1:0] != 2'b00);
`else
        misal = 1'b0;
`endif
        err   = misal;
        rdata = 32'd0;
        if (misal) return;
        if (we) begin
            if (size) begin
                for (int b = 0; b < 4; b++) refMem[base + b] = wdata[8*b +: 8];
            end else begin
                refMem[int'(addr)] = wdata[7:0];
            end
        end else if (size) begin
            rdata = {refMem[base + 3], refMem[base + 2], refMem[base + 1], refMem[base]};
        end else if (uns) begin
            rdata = 32'(refMem[int'(addr)]);
        end else begin
            rdata = 32'($signed(refMem[int'(addr)]));
        end
    endfunction

    task automatic applyStimulus(input bit we, input bit size, input bit uns,
                                 input logic [11:0] addr, input logic [31:0] wdata);
        logic [31:0] r;
        logic        e;
        req_we    = we;
        req_size  = size;
        req_uns   = uns;
        req_addr  = addr;
        req_wdata = wdata;
        req_valid = 1'b1;
        for (int n = 0; n < 200; n++) begin
            if (req_ready) begin
                modelOp(we, size, uns, addr, wdata, r, e);
                expQ.push_back('{rdata: r, err: e, due: cycle + LAT + 1});
                lastAccept = cycle;
                step();
                req_valid = 1'b0;
                req_addr  = 'x;
                req_wdata = 'x;
                return;
            end
            step();
        end
        checks++;
        $display("[TB] FAIL accept_timeout: got no accept, expected accept within 200 cycles");
        req_valid = 1'b0;
    endtask

    task automatic waitDrain();
        for (int n = 0; n < 300 && expQ.size() > 0; n++) step();
        if (expQ.size() > 0) begin
            checks++;
            $display("[TB] FAIL drain_timeout: got %0d pending responses, expected 0", expQ.size());
        end
    endtask

    always @(posedge clk) begin
        if (randReady) begin
            #1;
            resp_ready = 1'($urandom_range(0, 1));
        end
    end

    // Monitor: every response cycle is compared against the scoreboard head.
    always @(negedge clk) begin
        if (!rst) begin
            inResp = 1'b0;
        end else if (resp_valid) begin
            if (expQ.size() == 0) begin
                checks++;
                $display("[TB] FAIL unexpected_resp: got resp_valid=1, expected no response");
            end else begin
                if (!inResp) checkOutput("latency", cycle, expQ[0].due);
                checkOutput("rdata", resp_rdata, expQ[0].rdata);
                checkOutput("err", 32'(resp_err), 32'(expQ[0].err));
                checkOutput("req_ready_in_resp", 32'(req_ready), 32'd0);
                inResp = 1'b1;
                if (resp_ready) begin
                    void'(expQ.pop_front());
                    inResp = 1'b0;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] saved [4];
        int         prevAccept;
        logic [9:0] idx;

        rst = 1'b0;
        repeat (3) step();
        checkOutput("reset_resp_valid", 32'(resp_valid), 32'd0);
        checkOutput("reset_resp_rdata", resp_rdata, 32'd0);
        checkOutput("reset_resp_err", 32'(resp_err), 32'd0);
        rst = 1'b1;
        step();
        checkOutput("reset_req_ready", 32'(req_ready), 32'd1);

        for (int i = 0; i < 16; i++) applyStimulus(1, 1, 0, 12'(i * 4), $urandom);
        applyStimulus(1, 1, 0, 12'hFFC, $urandom);

        applyStimulus(1, 1, 0, 12'h010, 32'hDEADBEEF);
        applyStimulus(0, 1, 0, 12'h010, '0);

        applyStimulus(1, 0, 0, 12'h013, 32'h00000080);
        applyStimulus(0, 0, 0, 12'h013, '0);
        applyStimulus(0, 0, 1, 12'h013, '0);
        applyStimulus(0, 1, 0, 12'h010, '0);
        waitDrain();
        checkOutput("model_sb_merge", {refMem[19], refMem[18], refMem[17], refMem[16]}, 32'h80ADBEEF);

        resp_ready = 1'b0;
        applyStimulus(0, 1, 0, 12'h010, '0);
        fork
            applyStimulus(0, 1, 0, 12'h014, '0);
            begin
                repeat (7) step();
                resp_ready = 1'b1;
            end
        join
        waitDrain();

        applyStimulus(0, 1, 0, 12'h012, '0);
        applyStimulus(1, 1, 0, 12'h012, 32'hCAFEF00D);
        applyStimulus(0, 1, 0, 12'h010, '0);
        waitDrain();

        for (int b = 0; b < 4; b++) saved[b] = refMem[32 + b];
        applyStimulus(1, 1, 0, 12'h020, 32'h12345678);
        rst = 1'b0;
        for (int b = 0; b < 4; b++) refMem[32 + b] = saved[b];
        expQ.delete();
        #1;
        checkOutput("midreset_resp_valid", 32'(resp_valid), 32'd0);
        step();
        step();
        rst = 1'b1;
        #1;
        checkOutput("release_req_ready", 32'(req_ready), 32'd1);
        step();
        applyStimulus(0, 1, 0, 12'h020, '0);
        waitDrain();

        resp_ready = 1'b1;
        applyStimulus(0, 1, 0, 12'h004, '0);
        for (int i = 0; i < 3; i++) begin
            prevAccept = lastAccept;
            applyStimulus(0, 1, 0, 12'h008, '0);
            checkOutput("throughput_spacing", 32'(lastAccept - prevAccept), 32'(LAT + 2));
        end
        waitDrain();

        applyStimulus(1, 0, 0, 12'hFFF, 32'h000000A5);
        applyStimulus(0, 1, 0, 12'hFFF, '0);
        applyStimulus(0, 0, 0, 12'hFFF, '0);

        randReady = 1'b1;
        for (int i = 0; i < 60; i++) begin
            idx = ($urandom_range(0, 16) == 16) ? 10'd1023 : 10'($urandom_range(0, 15));
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), {idx, 2'($urandom_range(0, 3))}, $urandom);
            if ($urandom_range(0, 3) == 0) step();
        end
        randReady = 1'b0;
        #2;
        resp_ready = 1'b1;
        waitDrain();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
